// File: rtl/fact_job_ctrl_if.sv
// Signal bundle for fact_job_ctrl: slave register window, M1 bus master port,
// factorial core handshake and interrupt line.
interface fact_job_ctrl_if;
    logic        S_sel;
    logic        S_wr;
    logic [3:0]  S_address;
    logic [31:0] S_din;
    logic [31:0] S_dout;
    logic        M1_req;
    logic        M1_grant;
    logic        M1_wr;
    logic [7:0]  M1_address;
    logic [31:0] M1_dout;
    logic [31:0] M_din;
    logic        core_start;
    logic [31:0] core_n;
    logic        core_done;
    logic [63:0] core_result;
    logic        interrupt;

    modport master (
        input  S_sel, S_wr, S_address, S_din,
        output S_dout,
        output M1_req, M1_wr, M1_address, M1_dout,
        input  M1_grant, M_din,
        output core_start, core_n,
        input  core_done, core_result,
        output interrupt
    );

    modport slave (
        output S_sel, S_wr, S_address, S_din,
        input  S_dout,
        input  M1_req, M1_wr, M1_address, M1_dout,
        output M1_grant, M_din,
        input  core_start, core_n,
        output core_done, core_result,
        input  interrupt
    );
endinterface

// File: rtl/fact_job_ctrl.sv
// Job sequencer: drains FIFOTOP_IN operands through the factorial core into FIFOTOP_OUT.
// Optional macro FACT_RELEASE_BUS_EN releases the bus while the core computes.
module fact_job_ctrl #(
    parameter logic [7:0] IN_DATA_ADDR  = 8'h11,
    parameter logic [7:0] IN_CNT_ADDR   = 8'h13,
    parameter logic [7:0] OUT_DATA_ADDR = 8'h21
) (
    input logic             clk,
    input logic             reset_n,
    fact_job_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, REQ, RD_CNT, CNT_W, RD_DAT, DAT_W, CALC, REREQ, WR_HI, WR_LO, FIN
    } state_t;

    state_t      state;
    logic        busy;
    logic        done;
    logic        int_en;
    logic        req;
    logic        start;
    logic [31:0] n_reg;
    logic [63:0] result;
    logic [7:0]  result_cnt;
    logic [31:0] s_dout;
    logic [31:0] rdata;
    logic        bus_wr;
    logic [7:0]  bus_addr;
    logic [31:0] bus_data;
    logic        reg_wr;
    logic        reg_rd;
    logic        start_cmd;
    logic        unused_din;

    assign reg_wr     = bus.S_sel & bus.S_wr;
    assign reg_rd     = bus.S_sel & ~bus.S_wr;
    assign start_cmd  = reg_wr && (bus.S_address == 4'h3) && bus.S_din[0];
    assign unused_din = ^bus.S_din[31:1];

    always_comb begin
        rdata = '0;
        case (bus.S_address)
            4'h1:    rdata = {31'b0, int_en};
            4'h4:    rdata = {16'b0, result_cnt, 6'b0, done, busy};
            default: rdata = '0;
        endcase
    end

    // Bus action is gated by the current grant so nothing leaks onto the bus while it is owned elsewhere
    always_comb begin
        bus_wr   = 1'b0;
        bus_addr = '0;
        bus_data = '0;
        if (bus.M1_grant) begin
            case (state)
                RD_CNT: bus_addr = IN_CNT_ADDR;
                RD_DAT: bus_addr = IN_DATA_ADDR;
                WR_HI: begin
                    bus_wr   = 1'b1;
                    bus_addr = OUT_DATA_ADDR;
                    bus_data = result[63:32];
                end
                WR_LO: begin
                    bus_wr   = 1'b1;
                    bus_addr = OUT_DATA_ADDR;
                    bus_data = result[31:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            int_en     <= 1'b0;
            req        <= 1'b0;
            start      <= 1'b0;
            n_reg      <= '0;
            result     <= '0;
            result_cnt <= '0;
            s_dout     <= '0;
        end else begin
            start <= 1'b0;
            if (reg_rd) s_dout <= rdata;
            if (reg_wr && bus.S_address == 4'h1) int_en <= bus.S_din[0];
            if (reg_wr && bus.S_address == 4'h2) done <= 1'b0;
            case (state)
                IDLE: if (start_cmd) begin
                    state      <= REQ;
                    busy       <= 1'b1;
                    req        <= 1'b1;
                    result_cnt <= '0;
                end
                REQ:    if (bus.M1_grant) state <= RD_CNT;
                RD_CNT: if (bus.M1_grant) state <= CNT_W;
                CNT_W: begin
                    if (bus.M_din[3:0] == 4'd0) begin
                        state <= FIN;
                        req   <= 1'b0;
                    end else begin
                        state <= RD_DAT;
                    end
                end
                RD_DAT: if (bus.M1_grant) state <= DAT_W;
                DAT_W: begin
                    n_reg <= bus.M_din;
                    start <= 1'b1;
                    state <= CALC;
`ifdef FACT_RELEASE_BUS_EN
                    req   <= 1'b0;
`endif
                end
                CALC: if (bus.core_done) begin
                    result <= bus.core_result;
`ifdef FACT_RELEASE_BUS_EN
                    req    <= 1'b1;
                    state  <= REREQ;
`else
                    state  <= WR_HI;
`endif
                end
                REREQ: if (bus.M1_grant) state <= WR_HI;
                WR_HI: if (bus.M1_grant) state <= WR_LO;
                WR_LO: if (bus.M1_grant) begin
                    if (result_cnt != 8'hFF) result_cnt <= result_cnt + 8'd1;
                    state <= RD_CNT;
                end
                // Placed after the INT_CLR handling so a same-cycle clear loses to the set
                FIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.S_dout     = s_dout;
    assign bus.M1_req     = req;
    assign bus.M1_wr      = bus_wr;
    assign bus.M1_address = bus_addr;
    assign bus.M1_dout    = bus_data;
    assign bus.core_start = start;
    assign bus.core_n     = n_reg;
    assign bus.interrupt  = done & int_en;
endmodule
